alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the combinational MIC-1 ALU. It keeps the 6-bit {F0,F1,ENA,ENB,INVA,INC} function encoding and generalises the datapath width. It adds the MIC-1 shifter (SLL8/SRA1), a carry flag, an illegal-code error flag and valid/ready handshakes with backpressure. N/Z are captured into architectural flag registers for the microsequencer's JAMN/JAMZ logic.

---
 rtl/alu_pipe.sv | 180 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined MIC-1 ALU with a post-ALU shifter, carry and
// illegal-code flags, valid/ready handshakes and architectural N/Z flags.
module alu_pipe #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] ILLEGAL_FILL = 32'hABCABCAB
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             F0,
  input  logic             F1,
  input  logic             ENA,
  input  logic             ENB,
  input  logic             INVA,
  input  logic             INC,
  input  logic             SLL8,
  input  logic             SRA1,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] C_OUT,
  output logic             N,
  output logic             Z,
  output logic             CARRY,
  output logic             ERR,
  output logic             FLAG_N,
  output logic             FLAG_Z
);

  localparam logic [WIDTH-1:0] FILL = WIDTH'(ILLEGAL_FILL);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             n;
    logic             z;
    logic             carry;
    logic             ill;
    logic             sll8;
    logic             sra1;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             n;
    logic             z;
    logic             carry;
    logic             err;
  } s2_t;

  logic [5:0]       code_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_s;
  logic             carry_s;
  logic             ill_s;
  logic [WIDTH-1:0] shift_s;
  logic             shift_err_s;
  logic             s2_adv_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             s2_load_s;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic flag_n_q, flag_n_d;
  logic flag_z_q, flag_z_d;

  assign code_s = {F0, F1, ENA, ENB, INVA, INC};

  // Shared adder: X + Y + INC, with the carry out kept in the top bit.
  always_comb begin
    x_s   = ENA ? (INVA ? ~A : A) : (INVA ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
    y_s   = ENB ? B : {WIDTH{1'b0}};
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, INC};
  end

  // Function decode; only the listed codes are legal, everything else fills.
  always_comb begin
    alu_s   = FILL;
    carry_s = 1'b0;
    ill_s   = 1'b0;
    case (code_s)
      6'b011000: alu_s = A;
      6'b010100: alu_s = B;
      6'b011010: alu_s = ~A;
      6'b101100: alu_s = ~B;
      6'b001100: alu_s = A & B;
      6'b011100: alu_s = A | B;
      6'b010000: alu_s = {WIDTH{1'b0}};
      6'b111100, 6'b111101, 6'b111001, 6'b110101, 6'b111111,
      6'b110110, 6'b111011, 6'b110001, 6'b110010: begin
        alu_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Stage-2 shifter; both controls together pass through and flag an error.
  always_comb begin
    shift_s     = s1_q.res;
    shift_err_s = 1'b0;
    case ({s1_q.sll8, s1_q.sra1})
      2'b10:   shift_s = s1_q.res << 4'd8;
      2'b01:   shift_s = {s1_q.res[WIDTH-1], s1_q.res[WIDTH-1:1]};
      2'b11:   shift_err_s = 1'b1;
      default: shift_s = s1_q.res;
    endcase
  end

  assign s2_adv_s   = ~s2_valid_q | OUT_READY;
  assign IN_READY   = ~s1_valid_q | s2_adv_s;
  assign in_xfer_s  = IN_VALID & IN_READY;
  assign out_xfer_s = s2_valid_q & OUT_READY;
  assign s2_load_s  = s2_adv_s & s1_valid_q;

  // Next-state for both stages and the architectural flags; stalls hold.
  always_comb begin
    s1_valid_d = IN_READY ? IN_VALID : s1_valid_q;
    s2_valid_d = s2_adv_s ? s1_valid_q : s2_valid_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (in_xfer_s) begin
      s1_d.res   = alu_s;
      s1_d.n     = alu_s[WIDTH-1];
      s1_d.z     = (alu_s == {WIDTH{1'b0}});
      s1_d.carry = carry_s;
      s1_d.ill   = ill_s;
      s1_d.sll8  = SLL8;
      s1_d.sra1  = SRA1;
    end else begin
      s1_d = s1_q;
    end
    if (s2_load_s) begin
      s2_d.res   = shift_s;
      s2_d.n     = s1_q.n;
      s2_d.z     = s1_q.z;
      s2_d.carry = s1_q.carry;
      s2_d.err   = s1_q.ill | shift_err_s;
    end else begin
      s2_d = s2_q;
    end
    flag_n_d = out_xfer_s ? s2_q.n : flag_n_q;
    flag_z_d = out_xfer_s ? s2_q.z : flag_z_q;
  end

  // Pipeline and flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= {$bits(s1_t){1'b0}};
      s2_q       <= {$bits(s2_t){1'b0}};
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      flag_n_q   <= flag_n_d;
      flag_z_q   <= flag_z_d;
    end
  end

  assign OUT_VALID = s2_valid_q;
  assign C_OUT     = s2_q.res;
  assign N         = s2_q.n;
  assign Z         = s2_q.z;
  assign CARRY     = s2_q.carry;
  assign ERR       = s2_q.err;
  assign FLAG_N    = flag_n_q;
  assign FLAG_Z    = flag_z_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against a
// behavioural model of the MIC-1 functions, shifter and handshake.
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        n;
    logic        z;
    logic        carry;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, c_out;
  logic [5:0]  code;
  logic        sll8, sra1;
  logic        n, z, carry, err, flag_n, flag_z;

  logic        in16_valid, in16_ready, out16_valid;
  logic        out16_ready = 1'b1;
  logic [15:0] a16, b16, c16;
  logic        n16, z16, carry16, err16, fn16, fz16;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [5:0] legal_codes [16] = '{6'b011000, 6'b010100, 6'b011010, 6'b101100,
                                   6'b111100, 6'b111101, 6'b111001, 6'b110101,
                                   6'b111111, 6'b110110, 6'b111011, 6'b001100,
                                   6'b011100, 6'b010000, 6'b110001, 6'b110010};
  logic [31:0] legal_res [16] = '{32'd5, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFC,
                                  32'd8, 32'd9, 32'd6, 32'd4,
                                  32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFB, 32'd1,
                                  32'd7, 32'd0, 32'd1, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .F0(code[5]), .F1(code[4]), .ENA(code[3]), .ENB(code[2]),
    .INVA(code[1]), .INC(code[0]), .SLL8(sll8), .SRA1(sra1),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .C_OUT(c_out),
    .N(n), .Z(z), .CARRY(carry), .ERR(err), .FLAG_N(flag_n), .FLAG_Z(flag_z)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .IN_VALID(in16_valid), .IN_READY(in16_ready),
    .A(a16), .B(b16), .F0(code[5]), .F1(code[4]), .ENA(code[3]), .ENB(code[2]),
    .INVA(code[1]), .INC(code[0]), .SLL8(sll8), .SRA1(sra1),
    .OUT_VALID(out16_valid), .OUT_READY(out16_ready), .C_OUT(c16),
    .N(n16), .Z(z16), .CARRY(carry16), .ERR(err16), .FLAG_N(fn16), .FLAG_Z(fz16)
  );

  // Reference: each function written as the operation it names.
  function automatic exp_t ref_alu(input logic [5:0] c, input logic [31:0] x,
                                   input logic [31:0] y, input logic s8, input logic s1);
    exp_t        e;
    logic [31:0] r;
    logic [32:0] wide;
    logic        cy;
    logic        ill;
    cy  = 1'b0;
    ill = 1'b0;
    case (c)
      6'b011000: r = x;
      6'b010100: r = y;
      6'b011010: r = ~x;
      6'b101100: r = ~y;
      6'b111100: begin wide = {1'b0, x} + {1'b0, y};         r = wide[31:0]; cy = wide[32]; end
      6'b111101: begin wide = {1'b0, x} + {1'b0, y} + 33'd1; r = wide[31:0]; cy = wide[32]; end
      6'b111001: begin r = x + 32'd1; cy = (x == 32'hFFFF_FFFF); end
      6'b110101: begin r = y + 32'd1; cy = (y == 32'hFFFF_FFFF); end
      6'b111111: begin r = y - x;     cy = (y >= x); end
      6'b110110: begin r = y - 32'd1; cy = (y != 32'd0); end
      6'b111011: begin r = 32'd0 - x; cy = (x == 32'd0); end
      6'b001100: r = x & y;
      6'b011100: r = x | y;
      6'b010000: r = 32'd0;
      6'b110001: r = 32'd1;
      6'b110010: r = 32'hFFFF_FFFF;
      default: begin r = 32'hABCA_BCAB; ill = 1'b1; end
    endcase
    e.n     = r[31];
    e.z     = (r == 32'd0);
    e.carry = cy;
    e.err   = ill | (s8 & s1);
    if (s8 && s1)   e.res = r;
    else if (s8)    e.res = r << 8;
    else if (s1)    e.res = 32'($signed(r) >>> 1);
    else            e.res = r;
    return e;
  endfunction

  task automatic idle(input int cycles);
    in_valid   = 1'b0;
    in16_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in16_valid = 1'b0; out_ready = 1'b1;
    code = 6'd0; a = 32'd0; b = 32'd0; a16 = 16'd0; b16 = 16'd0;
    sll8 = 1'b0; sra1 = 1'b0;
    #12;
    tests_run++;
    if ({out_valid, c_out, n, z, carry, err, flag_n, flag_z, in_ready} !== {1'b0, 32'h0, 6'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h",
               {out_valid, c_out, n, z, carry, err, flag_n, flag_z, in_ready}, {1'b0, 32'h0, 6'b0, 1'b1});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = (i < 16);
      if (i < 16) begin code = legal_codes[i]; a = 32'd5; b = 32'd3; end
      @(posedge clk); #1;
      tests_run++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL back_to_back_latency: got out_valid=%b expected 0", out_valid);
        end
      end else begin
        e = ref_alu(legal_codes[i-1], 32'd5, 32'd3, 1'b0, 1'b0);
        if ({in_ready, out_valid, c_out, n, z, carry, err} !== {2'b11, legal_res[i-1], e.n, e.z, e.carry, 1'b0}) begin
          tests_failed++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", i-1,
                   {in_ready, out_valid, c_out, n, z, carry, err},
                   {2'b11, legal_res[i-1], e.n, e.z, e.carry, 1'b0});
        end
      end
    end
    idle(2);
  endtask

  task automatic test_illegal();
    code = 6'b000000; a = $urandom; b = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
    sll8 = 1'b0; sra1 = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in16_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in16_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, c_out, n, z, carry, err} !== {1'b1, 32'hABCA_BCAB, 4'b1001}) begin
      tests_failed++;
      $display("FAIL illegal_w32: got %h expected %h", {out_valid, c_out, n, z, carry, err}, {1'b1, 32'hABCA_BCAB, 4'b1001});
    end
    tests_run++;
    if ({out16_valid, c16, n16, z16, carry16, err16} !== {1'b1, 16'hBCAB, 4'b1001}) begin
      tests_failed++;
      $display("FAIL illegal_w16: got %h expected %h", {out16_valid, c16, n16, z16, carry16, err16}, {1'b1, 16'hBCAB, 4'b1001});
    end
    idle(2);
  endtask

  task automatic test_shifter();
    logic [1:0]  sh  [3] = '{2'b01, 2'b10, 2'b11};
    logic [35:0] exp [3] = '{{32'hC000_0078, 4'b1000}, {32'h0000_F000, 4'b1000}, {32'h8000_00F0, 4'b1001}};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin code = 6'b011000; a = 32'h8000_00F0; b = $urandom; {sll8, sra1} = sh[i]; end
      @(posedge clk); #1;
      if (i > 0) begin
        tests_run++;
        if ({out_valid, c_out, n, z, carry, err} !== {1'b1, exp[i-1]}) begin
          tests_failed++;
          $display("FAIL shifter[%0d]: got %h expected %h", i-1, {out_valid, c_out, n, z, carry, err}, {1'b1, exp[i-1]});
        end
      end
    end
    sll8 = 1'b0; sra1 = 1'b0;
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [5:0]  bp_code [3] = '{6'b011010, 6'b111100, 6'b111111};
    logic [31:0] bp_a    [3] = '{32'd1, 32'd1, 32'd2};
    logic [31:0] bp_b    [3] = '{32'd0, 32'd2, 32'd1};
    exp_t q[$];
    int   issued = 0;
    int   drained = 0;
    logic acc, xfer, exp_rdy;
    logic exp_fn = 1'b0;
    logic exp_fz = 1'b1;
    // Prime the flags with a zero result so the stall can be seen holding them.
    out_ready = 1'b1; code = 6'b010000; in_valid = 1'b1;
    @(posedge clk); #1;
    idle(2);
    tests_run++;
    if ({flag_n, flag_z} !== 2'b01) begin
      tests_failed++;
      $display("FAIL backpressure_prime_flags: got %b expected 01", {flag_n, flag_z});
    end
    for (int cyc = 0; cyc < 40 && drained < 3; cyc++) begin
      out_ready = (cyc >= 7);
      in_valid  = (issued < 3);
      if (issued < 3) begin code = bp_code[issued]; a = bp_a[issued]; b = bp_b[issued]; end
      @(negedge clk);
      acc     = in_valid & in_ready;
      xfer    = out_valid & out_ready;
      exp_rdy = !(q.size() == 2 && !out_ready);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL backpressure_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (q.size() == 0 || {c_out, n, z, carry, err} !== q[0]) begin
          tests_failed++;
          $display("FAIL backpressure_data cyc %0d: got %h queue depth %0d", cyc, {c_out, n, z, carry, err}, q.size());
        end
      end
      @(posedge clk); #1;
      if (acc) begin q.push_back(ref_alu(code, a, b, 1'b0, 1'b0)); issued++; end
      if (xfer && q.size() > 0) begin exp_fn = q[0].n; exp_fz = q[0].z; void'(q.pop_front()); drained++; end
      tests_run++;
      if ({flag_n, flag_z} !== {exp_fn, exp_fz}) begin
        tests_failed++;
        $display("FAIL backpressure_flags cyc %0d: got %b expected %b", cyc, {flag_n, flag_z}, {exp_fn, exp_fz});
      end
    end
    tests_run++;
    if (drained != 3) begin
      tests_failed++;
      $display("FAIL backpressure_drain: got %0d results expected 3", drained);
    end
    idle(1);
  endtask

  task automatic test_random();
    exp_t q[$];
    logic acc, xfer, exp_rdy;
    logic known = 1'b0;
    logic exp_fn = 1'b0;
    logic exp_fz = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 300) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 9) < 7);
        code      = ($urandom_range(0, 1) == 1) ? legal_codes[$urandom_range(0, 15)] : 6'($urandom_range(0, 63));
        a         = $urandom;
        b         = ($urandom_range(0, 7) == 0) ? a : $urandom;
        sll8      = ($urandom_range(0, 3) == 0);
        sra1      = ($urandom_range(0, 3) == 0);
      end else begin
        if (q.size() == 0) break;
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      acc     = in_valid & in_ready;
      xfer    = out_valid & out_ready;
      exp_rdy = !(q.size() == 2 && !out_ready);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL random_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL random_spurious cyc %0d: got %h with nothing outstanding", cyc, c_out);
        end else if ({c_out, n, z, carry, err} !== q[0]) begin
          tests_failed++;
          $display("FAIL random_data cyc %0d: got %h expected %h", cyc, {c_out, n, z, carry, err}, q[0]);
        end
      end
      @(posedge clk); #1;
      if (acc) q.push_back(ref_alu(code, a, b, sll8, sra1));
      if (xfer && q.size() > 0) begin exp_fn = q[0].n; exp_fz = q[0].z; void'(q.pop_front()); known = 1'b1; end
      if (known) begin
        tests_run++;
        if ({flag_n, flag_z} !== {exp_fn, exp_fz}) begin
          tests_failed++;
          $display("FAIL random_flags cyc %0d: got %b expected %b", cyc, {flag_n, flag_z}, {exp_fn, exp_fz});
        end
      end
    end
    tests_run++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_drain: got %0d outstanding, out_valid=%b expected 0 and 0", q.size(), out_valid);
    end
    sll8 = 1'b0; sra1 = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; code = 6'b011010; a = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    idle(2);
    tests_run++;
    if ({flag_n, flag_z} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midreset_prime_flags: got %b expected 10", {flag_n, flag_z});
    end
    out_ready = 1'b0; code = 6'b111100; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midreset_full: got %b expected 10", {out_valid, in_ready});
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, c_out, flag_n, flag_z, in_ready} !== {1'b0, 32'h0, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL midreset_async: got %h expected %h", {out_valid, c_out, flag_n, flag_z, in_ready}, {1'b0, 32'h0, 2'b00, 1'b1});
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_no_leftover[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
    end
    code = 6'b111001; a = 32'hFFFF_FFFF; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, c_out, n, z, carry, err} !== {1'b1, 32'h0, 4'b0110}) begin
      tests_failed++;
      $display("FAIL midreset_a_plus_1: got %h expected %h", {out_valid, c_out, n, z, carry, err}, {1'b1, 32'h0, 4'b0110});
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_illegal();
    test_shifter();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
